// File: rtl/mips_instr_encoder.sv
// Purpose  : packs symbolic instruction commands into 32-bit MIPS words and streams them into
//            instruction memory, one load session (start..finish) at a time.
// Latency  : an accepted legal command appears on imem_we/imem_addr/imem_wdata on the next cycle.
// Backpress: a pending write holds until imem_ready is high; cmd_ready drops while the write
//            is stalled, while the pending word fills the last slot, and outside LOAD.
// Ports    : clk/rst (sync, active-high); start/finish session pulses; cmd_* valid/ready command
//            input; imem_* backpressured write port; words_written/full session progress;
//            done session-closed pulse; err_illegal/err_count rejected-command reporting.
module mips_instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_shamt,
    input  logic [15:0]       cmd_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              full,
    output logic              done,
    output logic              err_illegal,
    output logic [7:0]        err_count
);

    localparam logic [4:0] OP_ADDU    = 5'd0;
    localparam logic [4:0] OP_SUBU    = 5'd1;
    localparam logic [4:0] OP_MULT    = 5'd2;
    localparam logic [4:0] OP_MULTU   = 5'd3;
    localparam logic [4:0] OP_AND     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_NOR     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_SLL     = 5'd8;
    localparam logic [4:0] OP_SRL     = 5'd9;
    localparam logic [4:0] OP_SRA     = 5'd10;
    localparam logic [4:0] OP_MFHI    = 5'd11;
    localparam logic [4:0] OP_MFLO    = 5'd12;
    localparam logic [4:0] OP_SLT     = 5'd13;
    localparam logic [4:0] OP_SLTU    = 5'd14;
    localparam logic [4:0] OP_NOP     = 5'd15;
    localparam logic [4:0] OP_GPIO_WR = 5'd16;
    localparam logic [4:0] OP_GPIO_RD = 5'd17;
    localparam logic [4:0] OP_LUI     = 5'd18;
    localparam logic [4:0] OP_ADDIU   = 5'd19;
    localparam logic [4:0] OP_ANDI    = 5'd20;
    localparam logic [4:0] OP_ORI     = 5'd21;
    localparam logic [4:0] OP_XORI    = 5'd22;
    localparam logic [4:0] OP_SLTI    = 5'd23;

    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_FULL} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              ill_q, ill_d;
    logic [7:0]        errc_q, errc_d;

    // ---------------------------------------------------------------
    // Command encoder: per-op field keep-masks, funct/opcode, legality
    // ---------------------------------------------------------------
    logic [5:0]  funct, opcode;
    logic        is_itype, legal;
    logic        keep_rs, keep_rt, keep_rd, keep_sh;
    logic [31:0] enc_word;

    always_comb begin
        funct    = 6'b000000;
        opcode   = 6'b000000;
        is_itype = 1'b0;
        legal    = 1'b1;
        keep_rs  = 1'b1;
        keep_rt  = 1'b1;
        keep_rd  = 1'b1;
        keep_sh  = 1'b0;
        case (cmd_op)
            OP_ADDU:  funct = 6'b100001;
            OP_SUBU:  funct = 6'b100011;
            OP_MULT:  begin funct = 6'b011000; keep_rd = 1'b0; end
            OP_MULTU: begin funct = 6'b011001; keep_rd = 1'b0; end
            OP_AND:   funct = 6'b100100;
            OP_OR:    funct = 6'b100101;
            OP_NOR:   funct = 6'b100111;
            OP_XOR:   funct = 6'b100110;
            // A zero shift amount would alias NOP / GPIO in the decoder, so refuse it.
            OP_SLL:   begin funct = 6'b000000; keep_rs = 1'b0; keep_sh = 1'b1; legal = (cmd_shamt != 5'd0); end
            OP_SRL:   begin funct = 6'b000010; keep_rs = 1'b0; keep_sh = 1'b1; legal = (cmd_shamt != 5'd0); end
            OP_SRA:   begin funct = 6'b000011; keep_rs = 1'b0; keep_sh = 1'b1; legal = (cmd_shamt != 5'd0); end
            OP_MFHI:  begin funct = 6'b010000; keep_rs = 1'b0; keep_rt = 1'b0; end
            OP_MFLO:  begin funct = 6'b010010; keep_rs = 1'b0; keep_rt = 1'b0; end
            OP_SLT:   funct = 6'b101010;
            OP_SLTU:  funct = 6'b101011;
            OP_NOP:   begin keep_rs = 1'b0; keep_rt = 1'b0; keep_rd = 1'b0; end
            // GPIO ops are the shift encodings with the shift amount pinned to 0.
            OP_GPIO_WR: begin funct = 6'b000010; keep_rs = 1'b0; end
            OP_GPIO_RD: begin funct = 6'b000011; keep_rs = 1'b0; end
            OP_LUI:   begin is_itype = 1'b1; opcode = 6'b001111; keep_rs = 1'b0; end
            OP_ADDIU: begin is_itype = 1'b1; opcode = 6'b001001; end
            OP_ANDI:  begin is_itype = 1'b1; opcode = 6'b001100; end
            OP_ORI:   begin is_itype = 1'b1; opcode = 6'b001101; end
            OP_XORI:  begin is_itype = 1'b1; opcode = 6'b001110; end
            OP_SLTI:  begin is_itype = 1'b1; opcode = 6'b001010; end
            default:  legal = 1'b0;
        endcase

        if (is_itype) begin
            enc_word = {opcode, (keep_rs ? cmd_rs : 5'd0), cmd_rt, cmd_imm};
        end else begin
            enc_word = {6'b000000,
                        (keep_rs ? cmd_rs    : 5'd0),
                        (keep_rt ? cmd_rt    : 5'd0),
                        (keep_rd ? cmd_rd    : 5'd0),
                        (keep_sh ? cmd_shamt : 5'd0),
                        funct};
        end
    end

    // ---------------------------------------------------------------
    // Handshake and session control
    // ---------------------------------------------------------------
    logic last_slot_pending, accept, commit;

    // The in-flight word already claims the final slot, so nothing more may be taken.
    assign last_slot_pending = we_q && (cnt_q == LAST_SLOT);
    assign cmd_ready = (state_q == S_LOAD) && (!we_q || imem_ready) && !last_slot_pending;
    assign accept    = cmd_valid && cmd_ready;
    assign commit    = we_q && imem_ready;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        errc_d  = errc_q;

        if (commit) begin
            we_d   = 1'b0;
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end

        // Accept may coincide with commit: the new word overwrites the slot just freed.
        if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                wdata_d = enc_word;
            end else begin
                ill_d = 1'b1;
                if (errc_q != 8'hFF) begin
                    errc_d = errc_q + 8'd1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (finish) begin
                    state_d = S_DRAIN;
                end else if (commit && (cnt_q == LAST_SLOT)) begin
                    state_d = S_FULL;
                end
            end
            S_DRAIN: begin
                if (!we_q || imem_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FULL: begin
                if (finish) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            errc_q  <= errc_d;
        end
    end

    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign words_written = cnt_q;
    assign full          = (state_q == S_FULL);
    assign done          = done_q;
    assign err_illegal   = ill_q;
    assign err_count     = errc_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Purpose  : self-checking bench for mips_instr_encoder (DEPTH=4 so the full path is reachable).
// Latency  : checks the 1-cycle accept-to-write latency and commit-to-counter update.
// Backpress: drives imem_ready low/random and checks the write is held and cmd_ready drops.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic              finish;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [4:0]        cmd_op;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [4:0]        cmd_shamt;
    logic [15:0]       cmd_imm;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_written;
    logic              full;
    logic              done;
    logic              err_illegal;
    logic [7:0]        err_count;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .finish       (finish),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rs       (cmd_rs),
        .cmd_rt       (cmd_rt),
        .cmd_rd       (cmd_rd),
        .cmd_shamt    (cmd_shamt),
        .cmd_imm      (cmd_imm),
        .imem_we      (imem_we),
        .imem_ready   (imem_ready),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .words_written(words_written),
        .full         (full),
        .done         (done),
        .err_illegal  (err_illegal),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          commit_idx = 0;
    logic        exp_ill = 1'b0;
    int          exp_err = 0;
    logic        rnd_ready = 1'b0;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: {legal, word}, written straight from the instruction formats.
    function automatic logic [32:0] model(input logic [4:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [15:0] imm);
        case (op)
            5'd0:  return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'h21};
            5'd1:  return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'h23};
            5'd2:  return {1'b1, 6'd0, rs, rt, 5'd0, 5'd0, 6'h18};
            5'd3:  return {1'b1, 6'd0, rs, rt, 5'd0, 5'd0, 6'h19};
            5'd4:  return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'h24};
            5'd5:  return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'h25};
            5'd6:  return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'h27};
            5'd7:  return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'h26};
            5'd8:  return {(sh != 5'd0), 11'd0, rt, rd, sh, 6'h00};
            5'd9:  return {(sh != 5'd0), 11'd0, rt, rd, sh, 6'h02};
            5'd10: return {(sh != 5'd0), 11'd0, rt, rd, sh, 6'h03};
            5'd11: return {1'b1, 16'd0, rd, 5'd0, 6'h10};
            5'd12: return {1'b1, 16'd0, rd, 5'd0, 6'h12};
            5'd13: return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'h2A};
            5'd14: return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'h2B};
            5'd15: return {1'b1, 32'h0000_0000};
            5'd16: return {1'b1, 11'd0, rt, rd, 5'd0, 6'h02};
            5'd17: return {1'b1, 11'd0, rt, rd, 5'd0, 6'h03};
            5'd18: return {1'b1, 6'h0F, 5'd0, rt, imm};
            5'd19: return {1'b1, 6'h09, rs, rt, imm};
            5'd20: return {1'b1, 6'h0C, rs, rt, imm};
            5'd21: return {1'b1, 6'h0D, rs, rt, imm};
            5'd22: return {1'b1, 6'h0E, rs, rt, imm};
            5'd23: return {1'b1, 6'h0A, rs, rt, imm};
            default: return 33'd0;
        endcase
    endfunction

    // Scoreboard step, run once per cycle on the falling edge.
    task automatic monitor();
        logic [32:0] m;
        logic [31:0] w;
        if (rst) begin
            exp_q.delete();
            commit_idx = 0;
            exp_ill    = 1'b0;
            exp_err    = 0;
            return;
        end
        chk("err_illegal", {31'd0, err_illegal}, {31'd0, exp_ill});
        chk("err_count", {24'd0, err_count}, exp_err);
        exp_ill = 1'b0;
        if (start) commit_idx = 0;
        if (imem_we && imem_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", {31'd0, imem_we}, 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("wdata", imem_wdata, w);
                chk("addr", {24'd0, imem_addr}, commit_idx);
                commit_idx++;
            end
        end
        if (cmd_valid && cmd_ready) begin
            m = model(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm);
            if (m[32]) exp_q.push_back(m[31:0]);
            else begin
                exp_ill = 1'b1;
                if (exp_err < 255) exp_err++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rnd_ready) imem_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        output int n);
        logic acc;
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_shamt = sh; cmd_imm = imm;
        cmd_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = cmd_ready;
            monitor();
            @(posedge clk);
            #1;
            if (rnd_ready) imem_ready = 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic end_session();
        int n;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        tick();
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_shamt = '0; cmd_imm = '0;
        imem_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_words", {23'd0, words_written}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);

        // Session 1: single ADDU, 1-cycle latency, counter after commit
        start_session();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, cyc);
        chk("addu_we", {31'd0, imem_we}, 32'd1);
        chk("addu_addr", {24'd0, imem_addr}, 32'd0);
        chk("addu_wdata", imem_wdata, 32'h0022_1821);
        tick();
        chk("addu_words", {23'd0, words_written}, 32'd1);
        chk("addu_we_off", {31'd0, imem_we}, 32'd0);
        end_session();

        // Session 2: LUI drops rs, back-to-back ADDIU
        start_session();
        send(5'd18, 5'd7, 5'd5, 5'd9, 5'd3, 16'hABCD, cyc);
        chk("lui_wdata", imem_wdata, 32'h3C05_ABCD);
        chk("lui_addr", {24'd0, imem_addr}, 32'd0);
        send(5'd19, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, cyc);
        chk("b2b_cycles", cyc, 32'd1);
        chk("addiu_wdata", imem_wdata, 32'h2408_FFFF);
        chk("addiu_addr", {24'd0, imem_addr}, 32'd1);
        tick();
        chk("s2_words", {23'd0, words_written}, 32'd2);
        end_session();

        // Session 3: shift, rejects, backpressure
        start_session();
        send(5'd8, 5'd9, 5'd2, 5'd4, 5'd3, 16'h1234, cyc);
        chk("sll_wdata", imem_wdata, 32'h0002_20C0);
        send(5'd8, 5'd9, 5'd2, 5'd4, 5'd0, 16'h0000, cyc);
        chk("sll0_ill", {31'd0, err_illegal}, 32'd1);
        chk("sll0_cnt", {24'd0, err_count}, 32'd1);
        chk("sll0_nowrite", {31'd0, imem_we}, 32'd0);
        chk("sll0_words", {23'd0, words_written}, 32'd1);
        tick();
        chk("ill_pulse_end", {31'd0, err_illegal}, 32'd0);
        send(5'd27, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0001, cyc);
        chk("op27_cnt", {24'd0, err_count}, 32'd2);
        imem_ready = 1'b0;
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, cyc);
        cmd_op = 5'd5; cmd_rs = 5'd3; cmd_rt = 5'd4; cmd_rd = 5'd5; cmd_shamt = 5'd0;
        cmd_valid = 1'b1;
        #1;
        chk("bp_ready0", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_we", {31'd0, imem_we}, 32'd1);
            chk("bp_addr", {24'd0, imem_addr}, 32'd1);
            chk("bp_wdata", imem_wdata, 32'h0022_1826);
            chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
        end
        chk("bp_words", {23'd0, words_written}, 32'd1);
        imem_ready = 1'b1;
        send(5'd5, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0000, cyc);
        chk("bp_release_cycles", cyc, 32'd1);
        chk("or_addr", {24'd0, imem_addr}, 32'd2);
        chk("or_wdata", imem_wdata, 32'h0064_2825);
        tick();
        end_session();

        // Session 4: fill to DEPTH, fifth command refused
        start_session();
        send(5'd5,  5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), cyc);
        send(5'd16, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), cyc);
        send(5'd17, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), cyc);
        send(5'd23, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), cyc);
        cmd_op = 5'd0; cmd_valid = 1'b1;
        repeat (3) tick();
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_words", {23'd0, words_written}, 32'd4);
        chk("full_we", {31'd0, imem_we}, 32'd0);
        cmd_valid = 1'b0;
        end_session();
        start_session();
        chk("restart_addr", {24'd0, imem_addr}, 32'd0);
        chk("restart_words", {23'd0, words_written}, 32'd0);
        chk("restart_full", {31'd0, full}, 32'd0);
        chk("restart_errcnt", {24'd0, err_count}, 32'd2);

        // Session 5: finish together with an accepted command, drain waits for memory
        imem_ready = 1'b0;
        cmd_op = 5'd20; cmd_rs = 5'd2; cmd_rt = 5'd3; cmd_rd = 5'd0; cmd_shamt = 5'd0;
        cmd_imm = 16'h00F0;
        cmd_valid = 1'b1;
        finish = 1'b1;
        tick();
        cmd_valid = 1'b0;
        finish = 1'b0;
        chk("fin_we", {31'd0, imem_we}, 32'd1);
        chk("fin_wdata", imem_wdata, 32'h3043_00F0);
        repeat (2) tick();
        chk("drain_hold_done", {31'd0, done}, 32'd0);
        chk("drain_hold_we", {31'd0, imem_we}, 32'd1);
        imem_ready = 1'b1;
        tick();
        chk("drain_done", {31'd0, done}, 32'd1);
        chk("drain_words", {23'd0, words_written}, 32'd1);
        tick();
        chk("drain_done_clear", {31'd0, done}, 32'd0);

        // Session 6: reset while a write is stalled
        start_session();
        imem_ready = 1'b0;
        send(5'd11, 5'd5, 5'd6, 5'd7, 5'd2, 16'h0000, cyc);
        chk("mfhi_wdata", imem_wdata, 32'h0000_3810);
        rst = 1'b1;
        tick();
        chk("mrst_we", {31'd0, imem_we}, 32'd0);
        chk("mrst_addr", {24'd0, imem_addr}, 32'd0);
        chk("mrst_wdata", imem_wdata, 32'd0);
        chk("mrst_words", {23'd0, words_written}, 32'd0);
        chk("mrst_errcnt", {24'd0, err_count}, 32'd0);
        chk("mrst_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        imem_ready = 1'b1;
        tick();

        // Session 7: error counter saturation
        start_session();
        for (int i = 0; i < 260; i++) begin
            if (i % 5 == 0) send(5'(8 + i % 3), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, cyc);
            else            send(5'(24 + i % 8), 5'd1, 5'd2, 5'd3, 5'd1, 16'h0, cyc);
        end
        tick();
        chk("err_saturate", {24'd0, err_count}, 32'd255);
        chk("sat_words", {23'd0, words_written}, 32'd0);
        end_session();

        // Random sessions with random memory backpressure
        rnd_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            start_session();
            for (int k = 0; k < 3; k++) begin
                send(5'($urandom_range(0, 31)), 5'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), 16'($urandom), cyc);
            end
            end_session();
        end
        rnd_ready = 1'b0;
        imem_ready = 1'b1;
        tick();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Encoder counterpart to the EX-stage control decoder. It accepts symbolic instruction commands (operation select plus register, shift and immediate fields) over a valid/ready handshake. It packs each command into a 32-bit MIPS instruction word that the decoder recognises. It streams the words sequentially into instruction memory through a backpressured write port. It is used by the bench loader and the self-test program generator to fill instruction memory before the CPU is released from reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width.
DEPTH, 256, number of words that may be written per load session (must be ≤ 2**ADDR_W).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  pulse; opens a load session at word address 0.
finish  in  1  pulse; closes the session.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_op  in  5  operation select (encoding below).
cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields.
cmd_shamt  in  5  shift amount.
cmd_imm  in  16  immediate.
imem_we  out  1  write-valid to instruction memory.
imem_ready  in  1  memory accepts the write this cycle.
imem_addr  out  ADDR_W  word address.
imem_wdata  out  32  encoded instruction.
words_written  out  ADDR_W+1  words committed this session.
full  out  1  DEPTH words committed.
done  out  1  one-cycle pulse when the session closes.
err_illegal  out  1  one-cycle pulse when a command is rejected.
err_count  out  8  rejected commands, saturating at 255.

Behaviour:
- cmd_op encoding.
  - R-type, opcode 0, with funct in parentheses: 0 ADDU(100001), 1 SUBU(100011), 2 MULT(011000), 3 MULTU(011001), 4 AND(100100), 5 OR(100101), 6 NOR(100111), 7 XOR(100110), 8 SLL(000000), 9 SRL(000010), 10 SRA(000011), 11 MFHI(010000), 12 MFLO(010010), 13 SLT(101010), 14 SLTU(101011).
  - Special words: 15 NOP (word 0x00000000); 16 GPIO_WR (SRL with shamt 0); 17 GPIO_RD (SRA with shamt 0).
  - I-type, opcode in parentheses: 18 LUI(001111), 19 ADDIU(001001), 20 ANDI(001100), 21 ORI(001101), 22 XORI(001110), 23 SLTI(001010).
  - Codes 24–31 are illegal.
- Field packing.
  - R-type word = {6'b0, rs, rt, rd, shamt, funct}.
  - I-type word = {opcode, rs, rt, imm}.
  - Fields that are unused for an op are forced to 0: shamt for non-shifts; rs for shifts, GPIO ops and LUI; rd for MULT/MULTU; rs and rt for MFHI/MFLO.
- Rejection rules.
  - Illegal cmd_op is rejected.
  - SLL, SRL or SRA with cmd_shamt==0 is rejected, because the decoder interprets those words as NOP or GPIO.
  - A rejected command is consumed (handshake completes), nothing is written, err_illegal pulses the next cycle, and err_count increments (saturating).
- State machine: IDLE, LOAD, DRAIN, FULL.
  - IDLE: cmd_ready=0. start moves to LOAD with address 0 and words_written 0.
  - LOAD: cmd_ready = (!imem_we || imem_ready) && !last_slot_pending. An accepted legal command registers imem_wdata/imem_addr and raises imem_we on the next cycle (1-cycle latency).
  - imem_we and its data/address hold stable until imem_ready is sampled high. Then the address increments and words_written increments.
  - Once words_written reaches DEPTH → FULL: full=1, cmd_ready=0.
  - finish in LOAD → DRAIN. DRAIN waits for any pending write to complete, then goes to IDLE and pulses done.
  - finish in FULL → IDLE with a done pulse.
  - start outside IDLE is ignored. finish in IDLE is ignored.
- Simultaneous events:
  - finish together with an accepted command: the command is written, then DRAIN.
  - A write commit and a new accept in the same cycle are allowed; throughput is 1 word per cycle when imem_ready=1.
- Reset values: state IDLE; all outputs 0 (imem_addr=0, imem_wdata=0, words_written=0, err_count=0).
  - Reset mid-write drops the pending word. imem_we deasserts the cycle after rst is sampled.
- err_count persists across sessions; only rst clears it.

Test Plan:
- start; ADDU rs=1 rt=2 rd=3, imem_ready=1 → next cycle imem_we=1, addr 0, wdata 0x00221821; words_written=1.
- LUI rt=5 imm=0xABCD (rs=7 supplied) then ADDIU rt=8 imm=0xFFFF → 0x3C05ABCD at addr 0, 0x2408FFFF at addr 1.
- SLL rd=4 rt=2 shamt=3 → 0x000220C0. SLL with shamt=0 → consumed, no write, err_illegal pulse, err_count=1. cmd_op=27 → err_count=2.
- imem_ready held 0 for 4 cycles during a write → imem_we, addr and wdata stable, cmd_ready=0; release → commit, then the next word proceeds.
- DEPTH=4: stream 5 commands → 4 written, full=1, cmd_ready=0; finish → done pulse, IDLE; start → addr restarts at 0, err_count unchanged.
- rst asserted while imem_we=1 and imem_ready=0 → next cycle imem_we=0, IDLE, counters 0, err_count 0.
